mc_decoder: RTL and testbench

MC_DECODER -- requirements
Module: mc_decoder

---
 rtl/mc_decoder.sv | 186 ++++++++++++++++++
 tb/tb_mc_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mc_decoder.sv
// Multicycle control decoder: registered main FSM with Moore outputs,
// a combinational ALU decoder and PC-write logic.
// Ports:
//   CLK, Reset        - clock and synchronous active-high reset
//   Op, Funct, Rd     - instruction fields [27:26], [25:20], [15:12]
//   FlagW, PCS, RegW, MemW - write enables for the condition-gating stage
//   NextPC, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB - datapath control
//   ImmSrc, RegSrc, ALUControl - instruction-field decode
//   State             - current FSM state code (debug only)
module mc_decoder (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  state_e state_q, state_d;
  state_e out_state;
  logic   alu_op;
  logic   branch;
  logic   reg_w_raw;
  logic   alu_supported;

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused codes fall into the default and recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs; while Reset is high they decode as FETCH with writes masked
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_op    = 1'b0;
    branch    = 1'b0;
    reg_w_raw = 1'b0;
    MemW      = 1'b0;
    out_state = Reset ? S_FETCH : state_q;
    case (out_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR: begin
        alu_op = 1'b1;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: begin
        reg_w_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      MemW    = 1'b0;
    end
  end

  // ALU decode: unsupported opcodes yield ADD with no flag writes
  always_comb begin
    ALUControl    = 2'b00;
    alu_supported = 1'b0;
    FlagW         = 2'b00;
    if (alu_op) begin
      alu_supported = 1'b1;
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: begin
          ALUControl    = 2'b00;
          alu_supported = 1'b0;
        end
      endcase
      // Only ADD/SUB update C and V
      if (alu_supported) begin
        FlagW = {Funct[0], Funct[0] & ~ALUControl[1]};
      end
    end
    if (Reset) begin
      FlagW = 2'b00;
    end
  end

  // Register write and PC write (writing R15 redirects the PC)
  always_comb begin
    RegW = reg_w_raw & ~Reset;
    PCS  = ((reg_w_raw & (Rd == 4'hF)) | branch) & ~Reset;
  end

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign State  = StateW'(state_q);

endmodule

// File: tb/tb_mc_decoder.sv
// Directed bench for mc_decoder: walks each instruction class through the FSM
// and checks state codes and control outputs against hand-derived values.
module tb_mc_decoder;

  logic       CLK;
  logic       Reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  int errors = 0;
  int checks = 0;

  mc_decoder dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
    tick(); tick();
    // Reset: FETCH state, write enables masked, other outputs at FETCH values
    chk("rst_state",   8'(State), 8'd0);
    chk("rst_irwrite", 8'(IRWrite), 8'd0);
    chk("rst_nextpc",  8'(NextPC), 8'd0);
    chk("rst_regw_memw_pcs", 8'({RegW, MemW, PCS}), 8'd0);
    chk("rst_flagw",   8'(FlagW), 8'd0);
    chk("rst_srcs",    8'({ALUSrcA, ALUSrcB, ResultSrc}), 8'b01_10_10);

    // Load: 0,1,2,3,4,0
    Reset = 1'b0; #1;
    chk("ld_fetch_irw_npc", 8'({IRWrite, NextPC, AdrSrc}), 8'b110);
    chk("ld_immsrc_regsrc", 8'({ImmSrc, RegSrc}), 8'b01_10);
    tick(); chk("ld_s1", 8'(State), 8'd1);
    chk("ld_decode_outs", 8'({IRWrite, ALUSrcA, ALUSrcB, ResultSrc}), 8'b0_01_10_10);
    tick(); chk("ld_s2", 8'(State), 8'd2);
    chk("ld_memadr_srcs", 8'({ALUSrcA, ALUSrcB}), 8'b00_01);
    tick(); chk("ld_s3", 8'(State), 8'd3);
    chk("ld_memrd_outs", 8'({AdrSrc, RegW, ResultSrc}), 8'b1_0_00);
    tick(); chk("ld_s4", 8'(State), 8'd4);
    chk("ld_memwb_outs", 8'({RegW, PCS, ResultSrc}), 8'b1_0_01);
    tick(); chk("ld_s0", 8'(State), 8'd0);
    chk("ld_done_regw", 8'(RegW), 8'd0);

    // Store: 0,1,2,5,0
    Funct = 6'b011000;
    tick(); chk("st_s1", 8'(State), 8'd1);
    tick(); chk("st_s2", 8'(State), 8'd2);
    chk("st_memw_pre", 8'(MemW), 8'd0);
    tick(); chk("st_s5", 8'(State), 8'd5);
    chk("st_memwr_outs", 8'({MemW, AdrSrc, RegW}), 8'b110);
    tick(); chk("st_s0", 8'(State), 8'd0);
    chk("st_memw_post", 8'(MemW), 8'd0);

    // SUBS to R15: EXECR then ALUWB with PC write
    Op = 2'b00; Funct = 6'b000101; Rd = 4'hF;
    tick(); chk("dp_s1", 8'(State), 8'd1);
    chk("dp_decode_flagw", 8'(FlagW), 8'd0);
    tick(); chk("dp_s6", 8'(State), 8'd6);
    chk("dp_execr_alu", 8'({ALUControl, FlagW, ALUSrcB}), 8'b01_11_00);
    tick(); chk("dp_s8", 8'(State), 8'd8);
    chk("dp_aluwb_outs", 8'({RegW, PCS, ResultSrc, FlagW}), 8'b1_1_00_00);
    tick(); chk("dp_s0", 8'(State), 8'd0);

    // ANDS register: AND control, only N/Z flags written
    Funct = 6'b000001; Rd = 4'd2;
    tick(); tick(); chk("and_s6", 8'(State), 8'd6);
    chk("and_alu", 8'({ALUControl, FlagW}), 8'b10_10);
    tick(); chk("and_pcs", 8'({RegW, PCS}), 8'b10);
    tick();

    // Unsupported data-processing opcode: ADD control, no flag writes
    Funct = 6'b000111;
    tick(); tick(); chk("uns_alu", 8'({ALUControl, FlagW}), 8'b00_00);
    tick(); tick();

    // ADDS immediate: ADD with all flags
    Funct = 6'b101001;
    tick(); tick(); chk("adds_s7", 8'(State), 8'd7);
    chk("adds_alu", 8'({ALUControl, FlagW}), 8'b00_11);
    tick(); tick();

    // ORR immediate, no S
    Funct = 6'b111000;
    tick(); tick(); chk("orr_s7", 8'(State), 8'd7);
    chk("orr_alu", 8'({ALUControl, ALUSrcB, FlagW}), 8'b11_01_00);
    tick(); chk("orr_s8", 8'(State), 8'd8);
    chk("orr_pcs", 8'(PCS), 8'd0);
    tick(); chk("orr_s0", 8'(State), 8'd0);

    // Branch: 0,1,9,0
    Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
    tick(); tick(); chk("br_s9", 8'(State), 8'd9);
    chk("br_outs", 8'({PCS, ALUSrcA, ALUSrcB, ResultSrc}), 8'b1_10_01_10);
    chk("br_regsrc", 8'({ImmSrc, RegSrc}), 8'b10_01);
    tick(); chk("br_s0", 8'(State), 8'd0);

    // Undefined: 0,1,0 with no writes
    Op = 2'b11;
    tick(); chk("und_s1", 8'(State), 8'd1);
    chk("und_writes", 8'({RegW, MemW, PCS, FlagW}), 8'd0);
    tick(); chk("und_s0", 8'(State), 8'd0);

    // Reset asserted mid-store in MEMWR
    Op = 2'b01; Funct = 6'b011000;
    tick(); tick(); tick(); chk("rs_s5", 8'(State), 8'd5);
    Reset = 1'b1; #1;
    chk("rs_mask_in_memwr", 8'({MemW, RegW, IRWrite, NextPC}), 8'd0);
    tick(); chk("rs_s0", 8'(State), 8'd0);
    chk("rs_mask_fetch", 8'({MemW, RegW, IRWrite}), 8'd0);
    Reset = 1'b0; #1;
    chk("rs_release_irw", 8'(IRWrite), 8'd1);
    tick(); chk("rs_s1", 8'(State), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
